// File: rtl/key_event_pkg.sv
// Shared constants for the push-button event controller: register map,
// debounce limit reset value and the idle (released) key level.
package key_event_pkg;

    localparam logic [1:0] ADDR_DATA  = 2'd0;
    localparam logic [1:0] ADDR_MASK  = 2'd1;
    localparam logic [1:0] ADDR_EDGE  = 2'd2;
    localparam logic [1:0] ADDR_DBLIM = 2'd3;

    // 10 ms at 50 MHz
    localparam int DB_RESET_DEFAULT = 500000;

    // Keys are active-low, so the idle level is 1
    localparam logic KEY_RELEASED = 1'b1;

endpackage

// File: rtl/key_event_ctrl_debounce.sv
// Per-key front end: 2-FF synchroniser, debounce counter, stable level and a
// single-cycle press pulse. With KEY_EVENT_AUTOREPEAT_EN defined the pulse
// also fires periodically while the key stays held.
module key_debounce
    import key_event_pkg::*;
#(
    parameter int DB_W = 20
`ifdef KEY_EVENT_AUTOREPEAT_EN
    , parameter int REP_W      = 26
    , parameter int REP_DELAY  = 25000000
    , parameter int REP_PERIOD = 5000000
`endif
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            key_raw,
    input  logic [DB_W-1:0] db_limit,
    output logic            stable,
    output logic            press
);

    logic            sync_meta;
    logic            sync;
    logic [DB_W-1:0] cnt;
    logic [1:0]      sync_vld;
    logic            armed;
    logic            update;
    logic            press_evt;

    // two-stage synchroniser for the asynchronous pin
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_meta <= KEY_RELEASED;
            sync      <= KEY_RELEASED;
        end else begin
            sync_meta <= key_raw;
            sync      <= sync_meta;
        end
    end

    assign update = (sync != stable) && (cnt >= db_limit);

    // debounce: accept a new level after db_limit+1 consecutive differing cycles
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt    <= '0;
            stable <= KEY_RELEASED;
        end else if (sync == stable) begin
            cnt <= '0;
        end else if (cnt >= db_limit) begin
            stable <= sync;
            cnt    <= '0;
        end else if (cnt != '1) begin
            cnt <= cnt + DB_W'(1);
        end
    end

    // A key held through reset must not report a press: events are only
    // armed once a real (post-reset) synchronised sample shows it released.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_vld <= '0;
            armed    <= 1'b0;
        end else begin
            sync_vld <= {sync_vld[0], 1'b1};
            armed    <= armed | (sync_vld[1] && (sync == KEY_RELEASED));
        end
    end

    assign press_evt = update && (stable == KEY_RELEASED) && armed;

`ifdef KEY_EVENT_AUTOREPEAT_EN
    logic [REP_W-1:0] rep_cnt;
    logic             rep_hit;

    assign rep_hit = armed && (stable != KEY_RELEASED) && (rep_cnt == REP_W'(REP_DELAY - 1));

    // hold timer: first repeat after REP_DELAY, then every REP_PERIOD
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rep_cnt <= '0;
        end else if (stable == KEY_RELEASED) begin
            rep_cnt <= '0;
        end else if (rep_hit) begin
            rep_cnt <= REP_W'(REP_DELAY - REP_PERIOD);
        end else begin
            rep_cnt <= rep_cnt + REP_W'(1);
        end
    end

    assign press = press_evt | rep_hit;
`else
    assign press = press_evt;
`endif

endmodule

// File: rtl/key_event_ctrl.sv
// Avalon-MM push-button controller: debounced levels, write-1-to-clear press
// capture register, maskable level interrupt, programmable debounce limit.
// Optional autorepeat is built when KEY_EVENT_AUTOREPEAT_EN is defined.
module key_event_ctrl
    import key_event_pkg::*;
#(
    parameter int N_KEYS     = 4,
    parameter int DB_W       = 20,
    parameter int DB_RESET   = DB_RESET_DEFAULT,
    parameter int REP_W      = 26,
    parameter int REP_DELAY  = 25000000,
    parameter int REP_PERIOD = 5000000
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    input  logic [N_KEYS-1:0] in_port,
    output logic              irq
);

    logic [N_KEYS-1:0] stable;
    logic [N_KEYS-1:0] press;
    logic [N_KEYS-1:0] irq_mask;
    logic [N_KEYS-1:0] edge_cap;
    logic [N_KEYS-1:0] edge_cap_next;
    logic [DB_W-1:0]   db_limit;
    logic              wr_en;
    logic [31:0]       unused_wdata;

    // Upper write bits are don't-care for every register
    assign unused_wdata = writedata;

    // Repeat timing only makes sense with 0 < period <= delay
    if (REP_W < 1 || REP_PERIOD < 1 || REP_PERIOD > REP_DELAY) begin : g_rep_cfg_bad
    end

    for (genvar i = 0; i < N_KEYS; i++) begin : g_key
        key_debounce #(
            .DB_W(DB_W)
`ifdef KEY_EVENT_AUTOREPEAT_EN
            , .REP_W(REP_W)
            , .REP_DELAY(REP_DELAY)
            , .REP_PERIOD(REP_PERIOD)
`endif
        ) u_key_debounce (
            .clk      (clk),
            .reset_n  (reset_n),
            .key_raw  (in_port[i]),
            .db_limit (db_limit),
            .stable   (stable[i]),
            .press    (press[i])
        );
    end

    assign wr_en = chipselect && !write_n;

    // capture update: W1C first, then new events so a coincident set wins
    always_comb begin
        edge_cap_next = edge_cap;
        if (wr_en && (address == ADDR_EDGE)) begin
            edge_cap_next = edge_cap & ~writedata[N_KEYS-1:0];
        end
        edge_cap_next = edge_cap_next | press;
    end

    // control registers and interrupt
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_mask <= '0;
            edge_cap <= '0;
            db_limit <= DB_W'(DB_RESET);
            irq      <= 1'b0;
        end else begin
            edge_cap <= edge_cap_next;
            irq      <= |(edge_cap_next & irq_mask);
            if (wr_en) begin
                case (address)
                    ADDR_MASK:  irq_mask <= writedata[N_KEYS-1:0];
                    ADDR_DBLIM: db_limit <= writedata[DB_W-1:0];
                    default: ;
                endcase
            end
        end
    end

    // read mux, registered every cycle regardless of chipselect
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
        end else begin
            case (address)
                ADDR_DATA: readdata <= 32'(stable);
                ADDR_MASK: readdata <= 32'(irq_mask);
                ADDR_EDGE: readdata <= 32'(edge_cap);
                default:   readdata <= 32'(db_limit);
            endcase
        end
    end

endmodule

// File: tb/tb_key_event_ctrl.sv
// Self-checking bench for key_event_ctrl (db_limit shortened to 3 / 0,
// REP_DELAY=20, REP_PERIOD=8 so autorepeat builds are quick).
module tb_key_event_ctrl;
    import key_event_pkg::*;

    logic        clk;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [3:0]  in_port;
    logic        irq;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] exp_q[$];
    string       tag_q[$];
    int          ev_q[$];

    key_event_ctrl #(
        .N_KEYS(4), .DB_W(20), .DB_RESET(500000),
        .REP_W(26), .REP_DELAY(20), .REP_PERIOD(8)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .in_port    (in_port),
        .irq        (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // read: expectation queued with the address, compared when data returns
    task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string tag);
        address = a;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        @(negedge clk);
        check_eq(tag_q.pop_front(), readdata, exp_q.pop_front());
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n    = 1'b0;
        address    = ADDR_DATA;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        in_port    = 4'hF;
        idle(3);
        check_eq("rst_readdata", readdata, 32'h0);
        check_eq("rst_irq", 32'(irq), 32'h0);
        reset_n = 1'b1;

        rd(ADDR_DATA, 32'h0000000F, "rst_data");
        rd(ADDR_DBLIM, 32'd500000, "rst_dblim");
        rd(ADDR_MASK, 32'h0, "rst_mask");
        rd(ADDR_EDGE, 32'h0, "rst_edge");

        wr(ADDR_DBLIM, 32'd3);
        rd(ADDR_DBLIM, 32'd3, "dblim_wr");

        // 3-cycle glitch is one cycle short of the required 4
        in_port[0] = 1'b0;
        idle(3);
        in_port[0] = 1'b1;
        idle(8);
        rd(ADDR_EDGE, 32'h0, "glitch_edge");
        rd(ADDR_DATA, 32'hF, "glitch_data");

        // real press: stable updates at edge 6 after the fall, read shows it one later
        address    = ADDR_DATA;
        in_port[0] = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            if (k == 6) check_eq("press_data_pre", readdata, 32'hF);
            if (k == 7) check_eq("press_data", readdata, 32'hE);
        end
        rd(ADDR_EDGE, 32'h1, "press_edge");
        check_eq("irq_masked", 32'(irq), 32'h0);

        // release creates no event
        wr(ADDR_EDGE, 32'h1);
        rd(ADDR_EDGE, 32'h0, "w1c_edge");
        in_port[0] = 1'b1;
        idle(10);
        rd(ADDR_EDGE, 32'h0, "release_no_evt");
        rd(ADDR_DATA, 32'hF, "release_data");

        // interrupt set / clear
        in_port[0] = 1'b0;
        idle(10);
        rd(ADDR_EDGE, 32'h1, "press2_edge");
        wr(ADDR_MASK, 32'h1);
        idle(1);
        check_eq("irq_on", 32'(irq), 32'h1);
        wr(ADDR_EDGE, 32'h1);
        check_eq("irq_clr", 32'(irq), 32'h0);
        rd(ADDR_EDGE, 32'h0, "edge_clr");

        // masking a pending bit
        in_port[0] = 1'b1;
        idle(10);
        in_port[0] = 1'b0;
        idle(10);
        check_eq("irq_pend", 32'(irq), 32'h1);
        wr(ADDR_MASK, 32'h0);
        idle(1);
        check_eq("irq_mask_off", 32'(irq), 32'h0);
        wr(ADDR_MASK, 32'h1);
        idle(1);
        check_eq("irq_mask_on", 32'(irq), 32'h1);
        wr(ADDR_EDGE, 32'h1);
        in_port[0] = 1'b1;
        idle(10);

        // key2 event lands on the same edge as a W1C of bit2
        in_port[2] = 1'b0;
        idle(5);
        wr(ADDR_EDGE, 32'h4);
        rd(ADDR_EDGE, 32'h4, "set_wins");
        check_eq("irq_unmasked_bit", 32'(irq), 32'h0);
        wr(ADDR_EDGE, 32'h4);
        rd(ADDR_EDGE, 32'h0, "set_wins_clr");
        in_port[2] = 1'b1;
        idle(10);

        // reset in the middle of key1's debounce (cnt=2 of 3)
        address    = ADDR_DATA;
        in_port[1] = 1'b0;
        idle(4);
        check_eq("pre_rst_data", readdata, 32'hF);
        reset_n = 1'b0;
        #1;
        check_eq("rst_mid_readdata", readdata, 32'h0);
        check_eq("rst_mid_irq", 32'(irq), 32'h0);
        idle(2);
        reset_n = 1'b1;
        rd(ADDR_DBLIM, 32'd500000, "rst_mid_dblim");
        rd(ADDR_MASK, 32'h0, "rst_mid_mask");
        wr(ADDR_DBLIM, 32'd3);
        idle(15);
        rd(ADDR_DATA, 32'hD, "held_data");
        rd(ADDR_EDGE, 32'h0, "held_no_evt");
        in_port[1] = 1'b1;
        idle(10);
        in_port[1] = 1'b0;
        idle(10);
        rd(ADDR_EDGE, 32'h2, "repress_evt");
        wr(ADDR_EDGE, 32'h2);
        in_port[1] = 1'b1;
        idle(10);

        // autorepeat on key3, db_limit=0: press edge 3, repeats at +20, +28
        wr(ADDR_DBLIM, 32'd0);
        wr(ADDR_MASK, 32'h8);
        rd(ADDR_EDGE, 32'h0, "pre_rep_edge");
        ev_q.push_back(3);
`ifdef KEY_EVENT_AUTOREPEAT_EN
        ev_q.push_back(23);
        ev_q.push_back(31);
`endif
        address    = ADDR_EDGE;
        writedata  = 32'h8;
        in_port[3] = 1'b0;
        for (int c = 1; c <= 36; c++) begin
            @(negedge clk);
            chipselect = 1'b0;
            write_n    = 1'b1;
            if (irq) begin
                if (ev_q.size() > 0) check_eq("rep_event_cycle", 32'(c), 32'(ev_q.pop_front()));
                else                 check_eq("rep_extra_event", 32'(c), 32'h0);
                chipselect = 1'b1;
                write_n    = 1'b0;
            end
        end
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
        check_eq("rep_missing", 32'(ev_q.size()), 32'h0);
        in_port[3] = 1'b1;
        idle(5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
